emergency_meeting_ctrl: RTL and testbench

//  Sequences the "emergency meeting" overlay: on a trigger edge from game logic, runs a frame-timed

---
 rtl/emergency_meeting_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_emergency_meeting_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/emergency_meeting_ctrl.sv
// Emergency-meeting overlay sequencer: frame-timed blink/hold animation plus 2x-scaled
// megaphone sprite address generation and a registered pixel stage for the color mapper.
module emergency_meeting_ctrl #(
  parameter int       SPRITE_W     = 64,
  parameter int       SPRITE_H     = 64,
  parameter int       SCALE_SHIFT  = 1,
  parameter int       ORIGIN_X     = 256,
  parameter int       ORIGIN_Y     = 176,
  parameter int       BLINK_FRAMES = 8,
  parameter int       BLINK_COUNT  = 3,
  parameter int       HOLD_FRAMES  = 120,
  parameter logic [2:0] TRANSP     = 3'd0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        trigger,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [2:0]  rom_data,
  output logic [18:0] rom_addr,
  output logic [2:0]  pixel_idx,
  output logic        draw_en,
  output logic        meeting_active,
  output logic        done
);

  // state     | meaning
  // IDLE      | overlay off, waiting for a trigger rising edge
  // BLINK_ON  | sprite shown for BLINK_FRAMES frames
  // BLINK_OFF | sprite hidden for BLINK_FRAMES frames
  // HOLD      | sprite shown steadily for HOLD_FRAMES frames
  // DONE      | single-cycle completion pulse, then back to IDLE
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BLINK_ON  = 3'd1,
    BLINK_OFF = 3'd2,
    HOLD      = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int FC_MAX = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
  localparam int FCW    = $clog2(FC_MAX + 1);
  localparam int BCW    = $clog2(BLINK_COUNT + 1);
  localparam int W_LOG2 = $clog2(SPRITE_W);

  localparam logic [FCW-1:0] BLINK_LAST = FCW'(BLINK_FRAMES - 1);
  localparam logic [FCW-1:0] HOLD_LAST  = FCW'(HOLD_FRAMES - 1);
  localparam logic [BCW-1:0] BC_LAST    = BCW'(BLINK_COUNT - 1);

  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + (SPRITE_W << SCALE_SHIFT));
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + (SPRITE_H << SCALE_SHIFT));

  state_t         state, state_d;
  logic [FCW-1:0] frame_cnt, frame_cnt_d;
  logic [BCW-1:0] blink_cnt, blink_cnt_d;
  logic [2:0]     fc_sync;
  logic           trig_q;
  logic           tick;
  logic           start;
  logic           visible;
  logic           inwin;
  logic [10:0]    dx, dy, off_x, off_y;
  logic [18:0]    tex_x, tex_y;

  // fc_sync[1:0] is the two-flop synchronizer; fc_sync[2] is the edge-detect history
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fc_sync <= 3'b000;
      trig_q  <= 1'b0;
    end else begin
      fc_sync <= {fc_sync[1:0], frame_clk};
      trig_q  <= trigger;
    end
  end

  assign tick  = fc_sync[1] & ~fc_sync[2];
  assign start = trigger & ~trig_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      blink_cnt <= '0;
    end else begin
      state     <= state_d;
      frame_cnt <= frame_cnt_d;
      blink_cnt <= blink_cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    frame_cnt_d = frame_cnt;
    blink_cnt_d = blink_cnt;
    case (state)
      IDLE: begin
        frame_cnt_d = '0;
        blink_cnt_d = '0;
        if (start) state_d = BLINK_ON;
      end
      BLINK_ON: begin
        if (tick) begin
          if (frame_cnt == BLINK_LAST) begin
            state_d     = BLINK_OFF;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt + 1'b1;
          end
        end
      end
      BLINK_OFF: begin
        if (tick) begin
          if (frame_cnt == BLINK_LAST) begin
            frame_cnt_d = '0;
            if (blink_cnt == BC_LAST) begin
              state_d = HOLD;
            end else begin
              state_d     = BLINK_ON;
              blink_cnt_d = blink_cnt + 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (frame_cnt == HOLD_LAST) begin
            state_d     = DONE;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        frame_cnt_d = '0;
        blink_cnt_d = '0;
      end
      default: begin
        state_d     = IDLE;
        frame_cnt_d = '0;
        blink_cnt_d = '0;
      end
    endcase
  end

  assign meeting_active = (state != IDLE);
  assign done           = (state == DONE);
  assign visible        = (state == BLINK_ON) || (state == HOLD);

  // Scan position widened to 11 bits so the window upper bounds cannot wrap
  assign dx    = {1'b0, DrawX};
  assign dy    = {1'b0, DrawY};
  assign inwin = (dx >= X_LO) && (dx < X_HI) && (dy >= Y_LO) && (dy < Y_HI);
  assign off_x = dx - X_LO;
  assign off_y = dy - Y_LO;
  assign tex_x = 19'(off_x >> SCALE_SHIFT);
  assign tex_y = 19'(off_y >> SCALE_SHIFT);

  always_comb begin
    rom_addr = '0;
    if (inwin) rom_addr = (tex_y << W_LOG2) + tex_x;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_idx <= 3'd0;
      draw_en   <= 1'b0;
    end else begin
      pixel_idx <= inwin ? rom_data : 3'd0;
      draw_en   <= visible & inwin & (rom_data != TRANSP);
    end
  end

endmodule

// File: tb/tb_emergency_meeting_ctrl.sv
// Directed bench for emergency_meeting_ctrl: reset, blink/hold timing, address map,
// transparency, completion pulse, retrigger rules and mid-sequence reset.
module tb_emergency_meeting_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic        trigger;
  logic [9:0]  DrawX, DrawY;
  logic [2:0]  rom_data;
  logic [18:0] rom_addr;
  logic [2:0]  pixel_idx;
  logic        draw_en;
  logic        meeting_active;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  emergency_meeting_ctrl dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .trigger        (trigger),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .rom_data       (rom_data),
    .rom_addr       (rom_addr),
    .pixel_idx      (pixel_idx),
    .draw_en        (draw_en),
    .meeting_active (meeting_active),
    .done           (done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    step(4);
    frame_clk = 1'b0;
    step(4);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) frame_pulse();
  endtask

  task automatic set_pix(input int x, input int y, input logic [2:0] d);
    DrawX    = 10'(x);
    DrawY    = 10'(y);
    rom_data = d;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_active"}, 32'(meeting_active), 0);
    check({tag, "_draw_en"}, 32'(draw_en), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pixel"}, 32'(pixel_idx), 0);
  endtask

  int addr_x [5] = '{257, 383, 384, 255, 256};
  int addr_y [5] = '{179, 303, 200, 200, 176};
  int addr_e [5] = '{64, 4095, 0, 0, 0};
  int addr_d [5] = '{1, 1, 0, 0, 1};

  initial begin
    bit got_done;
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    trigger   = 1'b0;
    set_pix(0, 0, 3'd0);
    #1;
    check_outputs_zero("reset");
    step(2);
    Reset_n = 1'b1;
    step(2);

    // idle: pixel stage runs but nothing is visible
    set_pix(256, 176, 3'd5);
    step(1);
    check("idle_pixel", 32'(pixel_idx), 5);
    check("idle_draw_en", 32'(draw_en), 0);
    check("idle_active", 32'(meeting_active), 0);

    trigger = 1'b1;
    step(1);
    check("start_active", 32'(meeting_active), 1);
    step(1);
    check("blink_on_draw_en", 32'(draw_en), 1);
    check("blink_on_pixel", 32'(pixel_idx), 5);

    pulses(7);
    check("tick7_still_on", 32'(draw_en), 1);
    pulses(1);
    check("tick8_blink_off", 32'(draw_en), 0);
    check("blink_off_active", 32'(meeting_active), 1);

    pulses(8);
    check("tick16_blink_on", 32'(draw_en), 1);
    pulses(8);
    check("tick24_blink_off", 32'(draw_en), 0);
    pulses(8);
    check("tick32_blink_on", 32'(draw_en), 1);
    pulses(8);
    check("tick40_blink_off", 32'(draw_en), 0);

    // retrigger during the last blink-off must not disturb timing
    pulses(4);
    trigger = 1'b0;
    step(2);
    trigger = 1'b1;
    step(2);
    check("retrig_active", 32'(meeting_active), 1);
    check("retrig_draw_en", 32'(draw_en), 0);
    pulses(3);
    check("tick47_still_off", 32'(draw_en), 0);
    pulses(1);
    check("tick48_hold", 32'(draw_en), 1);

    // hold: transparency and address map
    set_pix(256, 176, 3'd0);
    step(1);
    check("hold_transp_draw_en", 32'(draw_en), 0);
    set_pix(256, 176, 3'd7);
    step(1);
    check("hold_opaque_draw_en", 32'(draw_en), 1);
    check("hold_opaque_pixel", 32'(pixel_idx), 7);

    for (int i = 0; i < 5; i++) begin
      set_pix(addr_x[i], addr_y[i], 3'd5);
      #1;
      check($sformatf("addr_%0d_%0d", addr_x[i], addr_y[i]), 32'(rom_addr), 32'(addr_e[i]));
      step(1);
      check($sformatf("draw_en_%0d_%0d", addr_x[i], addr_y[i]), 32'(draw_en), 32'(addr_d[i]));
      check($sformatf("pixel_%0d_%0d", addr_x[i], addr_y[i]), 32'(pixel_idx),
            (addr_d[i] != 0) ? 32'd5 : 32'd0);
    end

    pulses(119);
    check("tick167_no_done", 32'(done), 0);
    check("tick167_active", 32'(meeting_active), 1);
    frame_clk = 1'b1;
    got_done  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("tick168_done", 32'(got_done), 1);
    step(1);
    frame_clk = 1'b0;
    check("done_one_cycle", 32'(done), 0);
    check("idle_after_done", 32'(meeting_active), 0);

    // trigger still high: no restart without a fresh edge
    step(5);
    check("held_trigger_no_restart", 32'(meeting_active), 0);
    trigger = 1'b0;
    set_pix(256, 176, 3'd5);
    step(1);
    trigger = 1'b1;
    step(1);
    check("restart_active", 32'(meeting_active), 1);
    step(1);
    check("restart_draw_en", 32'(draw_en), 1);

    pulses(48);
    check("second_hold_draw_en", 32'(draw_en), 1);
    Reset_n = 1'b0;
    trigger = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    step(2);
    Reset_n = 1'b1;
    step(2);
    check("post_reset_idle", 32'(meeting_active), 0);
    trigger = 1'b1;
    step(1);
    check("post_reset_start", 32'(meeting_active), 1);
    step(1);
    check("post_reset_blink_on", 32'(draw_en), 1);
    pulses(8);
    check("post_reset_blink_off", 32'(draw_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
